// File: rtl/cu_imm_seq_if.sv
// cu_imm_seq_if: start/IR request side and decoded control outputs of the
// immediate-class control unit.
//   master : drives start, IR, status; observes controlWord, k_mux, shamt,
//            busy, done, illegal
//   slave  : the control unit itself
interface cu_imm_seq_if #(
  parameter int CUL = 35
);
  logic           start;
  logic [31:0]    IR;
  logic [3:0]     status;
  logic [CUL:0]   controlWord;
  logic [2:0]     k_mux;
  logic [5:0]     shamt;
  logic           busy;
  logic           done;
  logic           illegal;

  modport master (
    output start, IR, status,
    input  controlWord, k_mux, shamt, busy, done, illegal
  );

  modport slave (
    input  start, IR, status,
    output controlWord, k_mux, shamt, busy, done, illegal
  );
endinterface

// File: rtl/cu_imm_seq.sv
// cu_imm_seq: sequenced control unit for LEGv8 immediate-class instructions
// (logic/arith immediates, LSL/LSR, MOVZ/MOVK/MOVN) in the multi-cycle datapath.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of cu_imm_seq_if (start/IR in, control word,
//             constant select, shift amount and handshake flags out)
//
// state | meaning
// IDLE  | waiting for start, all control outputs zero
// EX0   | first (often only) execute cycle
// EX1   | second cycle of MOVK / MOVN
// ERR   | one cycle after an undecodable IR, illegal pulses
module cu_imm_seq #(
  parameter int CUL   = 35,
  parameter bit HW_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  cu_imm_seq_if.slave bus
);
  localparam logic [4:0] FS_ADD = 5'b01000, FS_SUB = 5'b01001, FS_AND = 5'b00000,
                         FS_ANDN = 5'b00001, FS_ORR = 5'b00100, FS_XOR = 5'b01100,
                         FS_LSL = 5'b10000, FS_LSR = 5'b10100;

  typedef enum logic [1:0] {S_IDLE, S_EX0, S_EX1, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] irq, irq_nxt;

  function automatic logic is_logic(input logic [31:0] ir);
    return ir[28:22] == 7'b1001000;
  endfunction
  function automatic logic is_shift(input logic [31:0] ir);
    return ir[28:22] == 7'b1001101;
  endfunction
  function automatic logic is_math(input logic [31:0] ir);
    return ir[28:24] == 5'b10001;
  endfunction
  function automatic logic is_mov(input logic [31:0] ir);
    return ir[28:23] == 6'b100101;
  endfunction
  function automatic logic is_legal(input logic [31:0] ir);
    return is_logic(ir) || is_shift(ir) || is_math(ir) || (is_mov(ir) && ir[30:29] != 2'b01);
  endfunction
  // MOVN and MOVK each need a second cycle
  function automatic logic two_cycle(input logic [31:0] ir);
    return is_mov(ir) && (ir[30:29] == 2'b00 || ir[30:29] == 2'b11);
  endfunction

  always_comb begin
    state_nxt = state;
    irq_nxt   = irq;
    case (state)
      S_IDLE: if (bus.start) begin
        irq_nxt   = bus.IR;
        state_nxt = is_legal(bus.IR) ? S_EX0 : S_ERR;
      end
      S_EX0:   state_nxt = two_cycle(irq) ? S_EX1 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state/IR and then registered, so they
  // are glitch-free and line up with the state they describe.
  logic [4:0]   fs, sa;
  logic [1:0]   op;
  logic         c0, sl, active, second, last;
  logic [2:0]   k_d;
  logic [5:0]   sh_d;
  logic [35:0]  cw36;
  logic [CUL:0] cw_d;

  always_comb begin
    op     = irq_nxt[30:29];
    fs     = FS_AND;
    sa     = irq_nxt[9:5];
    c0     = 1'b0;
    sl     = 1'b0;
    k_d    = 3'b000;
    sh_d   = 6'd0;
    active = (state_nxt == S_EX0) || (state_nxt == S_EX1);
    second = (state_nxt == S_EX1);
    last   = second || (state_nxt == S_EX0 && !two_cycle(irq_nxt));
    if (is_logic(irq_nxt)) begin
      case (op)
        2'b01:   fs = FS_ORR;
        2'b10:   fs = FS_XOR;
        default: fs = FS_AND;
      endcase
      sl = (op == 2'b11);
    end else if (is_shift(irq_nxt)) begin
      fs   = irq_nxt[21] ? FS_LSL : FS_LSR;
      k_d  = 3'b110;
      sh_d = irq_nxt[15:10];
    end else if (is_math(irq_nxt)) begin
      fs = op[1] ? FS_SUB : FS_ADD;
      c0 = op[1];
      sl = op[0];
    end else if (is_mov(irq_nxt)) begin
      sh_d = HW_EN ? {irq_nxt[22:21], 4'b0000} : 6'd0;
      case (op)
        2'b11: begin
          fs  = second ? FS_ORR : FS_ANDN;
          k_d = second ? 3'b100 : 3'b101;
          sa  = irq_nxt[4:0];
        end
        2'b00: begin
          fs  = second ? FS_XOR : FS_ORR;
          k_d = second ? 3'b111 : 3'b100;
          sa  = second ? irq_nxt[4:0] : 5'd31;
        end
        default: begin
          fs  = FS_ORR;
          k_d = 3'b100;
        end
      endcase
    end
    cw36 = {fs, sa, irq_nxt[20:16], irq_nxt[4:0], 1'b1, c0, 2'b00, 1'b1, 1'b0, 1'b0,
            sl && last, 2'b00, 1'b0, 2'b00, 1'b0, last ? 2'b01 : 2'b00};
    if (!active) begin
      cw36 = '0;
      k_d  = 3'b000;
      sh_d = 6'd0;
    end
    cw_d        = '0;
    cw_d[35:0]  = cw36;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      irq             <= '0;
      bus.controlWord <= '0;
      bus.k_mux       <= 3'b000;
      bus.shamt       <= 6'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
    end else begin
      state           <= state_nxt;
      irq             <= irq_nxt;
      bus.controlWord <= cw_d;
      bus.k_mux       <= k_d;
      bus.shamt       <= sh_d;
      bus.busy        <= active;
      bus.done        <= active && last;
      bus.illegal     <= (state_nxt == S_ERR);
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.status, irq[31]};
endmodule

// File: tb/tb_cu_imm_seq.sv
module tb_cu_imm_seq;
  localparam logic [4:0] F_ADD = 5'b01000, F_SUB = 5'b01001, F_AND = 5'b00000,
                         F_ANDN = 5'b00001, F_ORR = 5'b00100, F_XOR = 5'b01100,
                         F_LSL = 5'b10000, F_LSR = 5'b10100;

  typedef struct packed {
    logic [35:0] cw;
    logic [2:0]  k;
    logic [5:0]  sh;
    logic        busy;
    logic        done;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] ir = '0;
  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  cu_imm_seq_if #(.CUL(35)) bus_a ();
  cu_imm_seq_if #(.CUL(35)) bus_b ();

  assign bus_a.start  = start;
  assign bus_a.IR     = ir;
  assign bus_a.status = 4'b1010;
  assign bus_b.start  = start;
  assign bus_b.IR     = ir;
  assign bus_b.status = 4'b0101;

  cu_imm_seq #(.CUL(35), .HW_EN(1'b1)) dut_a (.clock(clk), .reset_n(rst_n), .bus(bus_a.slave));
  cu_imm_seq #(.CUL(35), .HW_EN(1'b0)) dut_b (.clock(clk), .reset_n(rst_n), .bus(bus_b.slave));

  exp_t obs_a, obs_b;
  assign obs_a = {bus_a.controlWord[35:0], bus_a.k_mux, bus_a.shamt, bus_a.busy, bus_a.done, bus_a.illegal};
  assign obs_b = {bus_b.controlWord[35:0], bus_b.k_mux, bus_b.shamt, bus_b.busy, bus_b.done, bus_b.illegal};

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Control word assembled from named fields; constant fields w_reg=1, B_Sel=1.
  function automatic logic [35:0] mk_cw(input logic [4:0] fs, input logic [4:0] sa,
      input logic [4:0] sb, input logic [4:0] da, input bit c0, input bit sl, input bit last);
    return {fs, sa, sb, da, 1'b1, c0, 2'b00, 1'b1, 1'b0, 1'b0, sl, 2'b00, 1'b0, 2'b00,
            1'b0, last ? 2'b01 : 2'b00};
  endfunction

  function automatic exp_t cyc(input logic [35:0] cw, input logic [2:0] k,
      input logic [5:0] sh, input bit last);
    return {cw, k, sh, 1'b1, last, 1'b0};
  endfunction

  // Expected per-cycle behaviour of one instruction, followed by one idle cycle.
  function automatic void model(input logic [31:0] i, input bit hw);
    logic [4:0] rd = i[4:0];
    logic [4:0] rn = i[9:5];
    logic [4:0] rm = i[20:16];
    logic [1:0] op = i[30:29];
    logic [5:0] msh = hw ? 6'(i[22:21] * 16) : 6'd0;
    logic [4:0] fs;
    exp_t       e = '0;
    exp_q.delete();
    if (i[28:22] == 7'b1001000) begin
      fs = (op == 2'd1) ? F_ORR : (op == 2'd2) ? F_XOR : F_AND;
      exp_q.push_back(cyc(mk_cw(fs, rn, rm, rd, 0, op == 2'd3, 1), 3'b000, 6'd0, 1));
    end else if (i[28:22] == 7'b1001101) begin
      exp_q.push_back(cyc(mk_cw(i[21] ? F_LSL : F_LSR, rn, rm, rd, 0, 0, 1), 3'b110, i[15:10], 1));
    end else if (i[28:24] == 5'b10001) begin
      exp_q.push_back(cyc(mk_cw(op[1] ? F_SUB : F_ADD, rn, rm, rd, op[1], op[0], 1), 3'b000, 6'd0, 1));
    end else if (i[28:23] == 6'b100101 && op == 2'd2) begin
      exp_q.push_back(cyc(mk_cw(F_ORR, rn, rm, rd, 0, 0, 1), 3'b100, msh, 1));
    end else if (i[28:23] == 6'b100101 && op == 2'd3) begin
      exp_q.push_back(cyc(mk_cw(F_ANDN, rd, rm, rd, 0, 0, 0), 3'b101, msh, 0));
      exp_q.push_back(cyc(mk_cw(F_ORR, rd, rm, rd, 0, 0, 1), 3'b100, msh, 1));
    end else if (i[28:23] == 6'b100101 && op == 2'd0) begin
      exp_q.push_back(cyc(mk_cw(F_ORR, 5'd31, rm, rd, 0, 0, 0), 3'b100, msh, 0));
      exp_q.push_back(cyc(mk_cw(F_XOR, rd, rm, rd, 0, 0, 1), 3'b111, msh, 1));
    end else begin
      e.ill = 1'b1;
      exp_q.push_back(e);
      e.ill = 1'b0;
    end
    exp_q.push_back(e);
  endfunction

  // Issue one instruction at the current negedge; optionally keep start high
  // while busy and scramble IR every cycle, neither of which may matter.
  task automatic run(input string tag, input logic [31:0] ir_in, input bit hold);
    exp_t qa[$];
    exp_t qb[$];
    model(ir_in, 1'b1);
    qa = exp_q;
    model(ir_in, 1'b0);
    qb = exp_q;
    start = 1'b1;
    ir    = ir_in;
    @(posedge clk);
    for (int c = 0; c < qa.size(); c++) begin
      @(negedge clk);
      chk($sformatf("%s_hw1_c%0d", tag, c), 64'(obs_a), 64'(qa[c]));
      chk($sformatf("%s_hw0_c%0d", tag, c), 64'(obs_b), 64'(qb[c]));
      ir    = $urandom;
      start = hold && qa[c].busy && !qa[c].done;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          cls;
    #12;
    chk("reset_a", 64'(obs_a), 64'd0);
    chk("reset_b", 64'(obs_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a", 64'(obs_a), 64'd0);

    run("addi", 32'h91001441, 1'b0);
    run("subs", 32'hF1000441, 1'b0);
    run("movk", {1'b1, 2'b11, 6'b100101, 2'b10, 16'h1234, 5'd3}, 1'b1);
    run("movn", {1'b1, 2'b00, 6'b100101, 2'b01, 16'hABCD, 5'd4}, 1'b0);
    run("movz", {1'b1, 2'b10, 6'b100101, 2'b11, 16'h00FF, 5'd7}, 1'b1);
    run("lsr", {1'b1, 2'b10, 7'b1001101, 1'b0, 5'd9, 6'd7, 5'd5, 5'd6}, 1'b0);
    run("lsl", {1'b1, 2'b10, 7'b1001101, 1'b1, 5'd9, 6'd63, 5'd5, 5'd6}, 1'b1);
    run("ands", {1'b1, 2'b11, 7'b1001000, 1'b0, 12'hFFF, 5'd8, 5'd9}, 1'b0);
    run("ill_ff", 32'hFFFFFFFF, 1'b1);
    run("ill_mov01", {1'b1, 2'b01, 6'b100101, 2'b00, 16'h5555, 5'd2}, 1'b0);

    // Asynchronous abort during EX0 of MOVK
    start = 1'b1;
    ir    = {1'b1, 2'b11, 6'b100101, 2'b10, 16'h1234, 5'd3};
    @(posedge clk);
    #2;
    start = 1'b0;
    chk("abort_busy_before", 64'(bus_a.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_a", 64'(obs_a), 64'd0);
    chk("abort_b", 64'(obs_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_ex1_a", 64'(obs_a), 64'd0);
    @(negedge clk);
    chk("abort_idle_a", 64'(obs_a), 64'd0);

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 4);
      r   = $urandom;
      case (cls)
        0: r[28:22] = 7'b1001000;
        1: r[28:22] = 7'b1001101;
        2: r[28:24] = 5'b10001;
        3: r[28:23] = 6'b100101;
        default: ;
      endcase
      run($sformatf("rnd%0d", n), r, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cu_imm_seq.md
# cu_imm_seq

Sequenced control unit for the immediate-class LEGv8 instructions in the multi-cycle datapath: ANDI/ORRI/EORI/ANDIS, ADDI/ADDIS/SUBI/SUBIS, LSL/LSR, MOVZ/MOVK/MOVN. It latches IR on a start handshake and steps its own EX0/EX1 state register. For each cycle it drives the 36-bit control word, the K-constant mux select and the shift amount. It replaces the stateless decoder and adds MOVN, halfword-positioned moves (hw field), busy/done handshaking and illegal-opcode reporting.

## Interface
- CUL, 35: MSB index of controlWord. Must be ≥35; bits above 35 are driven 0.
- HW_EN, 1: 1 = MOV shamt is 16·IR[22:21]; 0 = hw ignored, MOV shamt is 0.
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- IR  in  32  instruction word; captured on an accepted start
- status  in  4  NZCV flags; unused, kept for port compatibility
- controlWord  out  CUL+1  {FS[4:0], SA[4:0], SB[4:0], DA[4:0], w_reg, C0, mem_cs[1:0], B_Sel, mem_write_en, IR_load, status_load, size[1:0], add_tri_sel, data_tri_sel[1:0], PC_sel, PC_FS[1:0]}
- k_mux  out  3  constant select: 000 imm12, 100 imm16, 101 imm16 mask, 110 shamt, 111 all-ones
- shamt  out  6  shift amount to the shifter
- busy  out  1  high in EX0 and EX1
- done  out  1  one-cycle pulse in the final execute cycle
- illegal  out  1  one-cycle pulse after start with an undecodable IR

## Operation
- Class decode on latched IR (IRq):
  - LOGIC: IRq[28:22]=1001000
  - SHIFT: IRq[28:22]=1001101
  - MATH: IRq[28:24]=10001
  - MOV: IRq[28:23]=100101
- op=IRq[30:29].
  - LOGIC: 00 AND, 01 ORR, 10 EOR, 11 ANDS.
  - MATH: 00 ADD, 01 ADDS, 10 SUB, 11 SUBS.
  - MOV: 00 MOVN, 10 MOVZ, 11 MOVK, 01 illegal.
  - SHIFT: IRq[21]=1 LSL, 0 LSR.
- States: IDLE, EX0, EX1, ERR. Encoding is free.
  - IDLE→EX0 on start with a legal IR.
  - IDLE→ERR on start with an illegal IR.
  - ERR→IDLE unconditionally.
  - EX0→EX1 for MOVK/MOVN; EX0→IDLE otherwise.
  - EX1→IDLE unconditionally.
- FS codes: ADD 01000, SUB 01001, AND 00000, ANDNOT 00001, ORR 00100, XOR 01100, LSL 10000, LSR 10100.
- Single-cycle ops, EX0:
  - FS per op.
  - k_mux: 000 for LOGIC/MATH, 110 for SHIFT.
  - MOVZ: ORR, k_mux 100.
- MOVK:
  - EX0: ANDNOT, k_mux 101, SA=DA=Rd.
  - EX1: ORR, k_mux 100, SA=DA=Rd.
- MOVN:
  - EX0: ORR, k_mux 100, SA=31.
  - EX1: XOR, k_mux 111, SA=DA=Rd.
- Field mapping: SA=IRq[9:5] except where stated above; SB=IRq[20:16]; DA=IRq[4:0].
- shamt:
  - SHIFT: IRq[15:10].
  - MOV: {IRq[22:21],4'b0000} when HW_EN=1, else 0.
  - Otherwise: 0.
- Constant fields in EX0/EX1: w_reg=1, B_Sel=1, all other memory, tri-state and IR_load fields 0.
- C0=1 for SUB/SUBS.
- status_load=1 only in the final cycle of ADDS/SUBS/ANDS.
- PC_FS=01 (PC+4) only in the final execute cycle, 00 otherwise.
- IDLE and ERR: controlWord all zero, k_mux 000, shamt 0.

## Timing
- Reset: state IDLE, IRq 0, busy/done/illegal 0, controlWord 0, k_mux 000, shamt 0.
- Reset is asynchronous; asserting it mid-operation aborts immediately. No write-back or PC update is issued afterwards.
- Outputs are decoded from the state and IRq registers, glitch-free relative to the IR input.
- Latency, start accepted at edge N:
  - EX0 is cycle N+1.
  - Single-cycle op: done in cycle N+1.
  - MOVK/MOVN: done in cycle N+2.
- start while busy or in ERR is ignored. IR changes while busy have no effect.
- Back-to-back: start may be reasserted in the cycle after done; the next op then has EX0 two cycles after the previous one.

## Test plan
- ADDI X1,X2,#5 (IR=0x91001441) with start → next cycle: FS=01000, SA=2, DA=1, C0=0, k_mux=000, PC_FS=01, done=1, busy=1. The cycle after: IDLE, controlWord=0.
- SUBS imm, op=11 → FS=01001, C0=1, status_load=1 in EX0 only.
- MOVK X3,#imm,LSL#32 (hw=10) → EX0: FS=00001, k_mux=101, shamt=32, PC_FS=00, done=0. EX1: FS=00100, k_mux=100, PC_FS=01, done=1. With HW_EN=0, shamt=0 in both cycles.
- MOVN X4 → EX0: ORR with SA=31, k_mux=100. EX1: XOR with k_mux=111, SA=DA=4.
- LSR, IR[21]=0, IR[15:10]=7 → FS=10100, k_mux=110, shamt=7. Illegal IR (e.g. 0xFFFFFFFF) → illegal pulses 1 cycle, w_reg=0 throughout.
- reset_n low during EX0 of MOVK → controlWord=0 and busy=0 asynchronously. start held high while busy → no second operation begins.
